// File: rtl/sram_bus_pkg.sv
// Shared types for the SRAM bus responder: FSM states, operation codes
// and the wait-counter width.
package sram_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Wide enough for the largest legal WAIT_STATES value (15).
    localparam int CNT_W = 4;

    // A request with both strobes high is serviced as a write.
    function automatic op_t decode_op(input logic rd, input logic wr);
        if (wr) begin
            return OP_WRITE;
        end else begin
            return (rd) ? OP_READ : OP_READ;
        end
    endfunction

endpackage

// File: rtl/sram_bus_responder_if.sv
// CPU request bus between the request unit (master) and the memory
// responder (slave).
interface sram_bus_responder_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();

    logic                  read_i;
    logic                  write_i;
    logic [ADDR_W-1:0]     adr_i;
    logic [DATA_W-1:0]     cpu_dat_i;
    logic [DATA_W/8-1:0]   sel_i;
    logic [DATA_W-1:0]     cpu_dat_o;
    logic                  busy_o;
    logic                  ack_o;

    modport master (
        output read_i, write_i, adr_i, cpu_dat_i, sel_i,
        input  cpu_dat_o, busy_o, ack_o
    );

    modport slave (
        input  read_i, write_i, adr_i, cpu_dat_i, sel_i,
        output cpu_dat_o, busy_o, ack_o
    );

endinterface

// File: rtl/sram_word_array.sv
// Word-addressed storage with byte-lane writes, a registered read port
// that holds its value between reads, and synchronous clear on reset.
module sram_word_array #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   adr,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    output logic [DATA_W-1:0]   rdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem_r [DEPTH];

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [LANES-1:0]  lane_en
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int l = 0; l < LANES; l++) begin
            if (lane_en[l]) begin
                res[8*l +: 8] = new_word[8*l +: 8];
            end else begin
                res[8*l +: 8] = old_word[8*l +: 8];
            end
        end
        return res;
    endfunction

    // Storage update and registered read; reset wins over any pending write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_r <= '{default: '0};
            rdata <= '0;
        end else begin
            if (we) begin
                mem_r[adr] <= merge_lanes(mem_r[adr], wdata, sel);
            end
            if (re) begin
                rdata <= mem_r[adr];
            end
        end
    end

endmodule

// File: rtl/sram_bus_responder.sv
// Target end of the CPU request bus: captures one request while idle, waits
// WAIT_STATES cycles, then performs it against the word array and pulses ack.
module sram_bus_responder
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_bus_responder_if.slave  bus
);

    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    op_t                   op_r;
    logic [ADDR_W-1:0]     adr_r;
    logic [DATA_W-1:0]     dat_r;
    logic [DATA_W/8-1:0]   sel_r;
    logic                  busy_r;
    logic                  ack_r;
    logic                  we_s;
    logic                  re_s;
    logic [DATA_W-1:0]     rdata_s;

    // Memory strobes fire only on the DONE edge, from the latched request.
    always_comb begin
        we_s = 1'b0;
        re_s = 1'b0;
        if (state_r == DONE) begin
            we_s = (op_r == OP_WRITE);
            re_s = (op_r == OP_READ);
        end else begin
            we_s = 1'b0;
            re_s = 1'b0;
        end
    end

    // Request FSM with wait counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= OP_READ;
            adr_r   <= '0;
            dat_r   <= '0;
            sel_r   <= '0;
            busy_r  <= 1'b0;
            ack_r   <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.read_i || bus.write_i) begin
                        op_r   <= decode_op(bus.read_i, bus.write_i);
                        adr_r  <= bus.adr_i;
                        dat_r  <= bus.cpu_dat_i;
                        sel_r  <= bus.sel_i;
                        busy_r <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_r <= WAIT;
                            cnt_r   <= CNT_W'(WAIT_STATES);
                        end else begin
                            state_r <= DONE;
                        end
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    ack_r   <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    sram_word_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s),
        .adr   (adr_r),
        .sel   (sel_r),
        .wdata (dat_r),
        .re    (re_s),
        .rdata (rdata_s)
    );

    assign bus.cpu_dat_o = rdata_s;
    assign bus.busy_o    = busy_r;
    assign bus.ack_o     = ack_r;

endmodule

// File: tb/tb_sram_bus_responder.sv
// Randomized bench for sram_bus_responder against a transaction-level memory
// model with exact busy/ack timing expectations.
module tb_sram_bus_responder;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int WS = 1;
    localparam int LN = DW / 8;

    logic clk;
    logic rst;

    sram_bus_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_bus_responder #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_STATES (WS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mem_m [2**AW];
    logic [DW-1:0] last_rd;

    task automatic check_value(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [LN-1:0] s);
        bus.read_i    = rd;
        bus.write_i   = wr;
        bus.adr_i     = a;
        bus.cpu_dat_i = d;
        bus.sel_i     = s;
    endtask

    task automatic drive_garbage;
        drive(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), LN'($urandom));
    endtask

    task automatic model_reset;
        for (int i = 0; i < 2**AW; i++) mem_m[i] = '0;
        last_rd = '0;
    endtask

    // Effect of one completed request on the memory model.
    task automatic model_apply(input logic rd, input logic wr, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [LN-1:0] s);
        if (wr) begin
            for (int l = 0; l < LN; l++)
                if (s[l]) mem_m[a][8*l +: 8] = d[8*l +: 8];
        end else if (rd) begin
            last_rd = mem_m[a];
        end
    endtask

    // Called just after acceptance edge N: busy for WS more edges, then ack.
    task automatic expect_handshake(input string tag, input bit scramble);
        for (int k = 1; k <= WS + 1; k++) begin
            if (scramble) drive_garbage();
            step();
            if (k <= WS) begin
                check_value({tag, "_busy_wait"}, 32'(bus.busy_o), 32'd1);
                check_value({tag, "_ack_wait"},  32'(bus.ack_o),  32'd0);
            end else begin
                check_value({tag, "_busy_ack"},  32'(bus.busy_o), 32'd0);
                check_value({tag, "_ack"},       32'(bus.ack_o),  32'd1);
                check_value({tag, "_data"},      bus.cpu_dat_o,   last_rd);
            end
        end
    endtask

    task automatic txn(input string tag, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [LN-1:0] s);
        drive(rd, wr, a, d, s);
        step();
        model_apply(rd, wr, a, d, s);
        check_value({tag, "_busy_acc"}, 32'(bus.busy_o), 32'd1);
        check_value({tag, "_ack_acc"},  32'(bus.ack_o),  32'd0);
        expect_handshake(tag, 1'b1);
        drive(1'b0, 1'b0, '0, '0, '0);
        step();
        check_value({tag, "_ack_after"},  32'(bus.ack_o),  32'd0);
        check_value({tag, "_busy_after"}, 32'(bus.busy_o), 32'd0);
        check_value({tag, "_hold"},       bus.cpu_dat_o,   last_rd);
    endtask

    initial begin
        logic rd;
        logic wr;

        model_reset();
        drive(1'b0, 1'b0, '0, '0, '0);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step();
            check_value("idle_busy", 32'(bus.busy_o), 32'd0);
            check_value("idle_ack",  32'(bus.ack_o),  32'd0);
            check_value("idle_dat",  bus.cpu_dat_o,   32'd0);
        end

        txn("rd3", 1'b1, 1'b0, 5'd3, 32'd0, 4'h0);
        check_value("rd3_zero", bus.cpu_dat_o, 32'h0000_0000);

        txn("wr5", 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF);
        txn("rd5", 1'b1, 1'b0, 5'd5, 32'd0, 4'h0);
        check_value("rd5_const", bus.cpu_dat_o, 32'hDEAD_BEEF);

        txn("wr5p", 1'b0, 1'b1, 5'd5, 32'h1122_3344, 4'h3);
        txn("rd5p", 1'b1, 1'b0, 5'd5, 32'd0, 4'h0);
        check_value("rd5p_const", bus.cpu_dat_o, 32'hDEAD_3344);

        txn("wr7", 1'b0, 1'b1, 5'd7, 32'h7777_CAFE, 4'hF);

        // read_i held high, address switched mid-flight, then accepted again without a gap
        drive(1'b1, 1'b0, 5'd5, 32'd0, 4'h0);
        step();
        model_apply(1'b1, 1'b0, 5'd5, 32'd0, 4'h0);
        check_value("b2b1_busy_acc", 32'(bus.busy_o), 32'd1);
        bus.adr_i = 5'd7;
        expect_handshake("b2b1", 1'b0);
        check_value("b2b1_const", bus.cpu_dat_o, 32'hDEAD_3344);
        step();
        model_apply(1'b1, 1'b0, 5'd7, 32'd0, 4'h0);
        check_value("b2b2_busy_acc", 32'(bus.busy_o), 32'd1);
        check_value("b2b2_ack_acc",  32'(bus.ack_o),  32'd0);
        expect_handshake("b2b2", 1'b1);
        check_value("b2b2_const", bus.cpu_dat_o, 32'h7777_CAFE);
        drive(1'b0, 1'b0, '0, '0, '0);
        step();

        txn("rdwr2", 1'b1, 1'b1, 5'd2, 32'hA5A5_A5A5, 4'hF);
        check_value("rdwr2_unchanged", bus.cpu_dat_o, 32'h7777_CAFE);
        txn("rd2", 1'b1, 1'b0, 5'd2, 32'd0, 4'h0);
        check_value("rd2_const", bus.cpu_dat_o, 32'hA5A5_A5A5);

        txn("wr5z", 1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 4'h0);
        txn("rd5z", 1'b1, 1'b0, 5'd5, 32'd0, 4'h0);
        check_value("rd5z_const", bus.cpu_dat_o, 32'hDEAD_3344);

        for (int n = 0; n < 80; n++) begin
            rd = 1'($urandom);
            wr = (rd) ? ($urandom_range(0, 3) == 0) : 1'b1;
            txn("rand", rd, wr, AW'($urandom), DW'($urandom), LN'($urandom));
        end

        // reset asserted while the write sits in DONE: no ack, no write, array cleared
        drive(1'b0, 1'b1, 5'd9, 32'h1234_5678, 4'hF);
        step();
        drive(1'b0, 1'b0, '0, '0, '0);
        for (int k = 0; k < WS; k++) step();
        rst = 1'b0;
        step();
        check_value("rstdone_ack",  32'(bus.ack_o),  32'd0);
        check_value("rstdone_busy", 32'(bus.busy_o), 32'd0);
        check_value("rstdone_dat",  bus.cpu_dat_o,   32'd0);
        rst = 1'b1;
        model_reset();
        step();
        check_value("post_rst_ack", 32'(bus.ack_o), 32'd0);
        txn("rd9", 1'b1, 1'b0, 5'd9, 32'd0, 4'h0);
        check_value("rd9_zero", bus.cpu_dat_o, 32'h0000_0000);
        txn("rd2r", 1'b1, 1'b0, 5'd2, 32'd0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_bus_responder.md
Name: sram_bus_responder

Overview:
- Memory-side responder for the CPU request bus: accepts read_i/write_i requests with adr_i, cpu_dat_i and sel_i.
- Services each request against an internal word-addressed SRAM array after a configurable number of wait states.
- Returns cpu_dat_o and handshakes through busy_o and ack_o.
- Sits between the CPU request unit and data/instruction storage; it is the target end of that bus.

Parameters:
- ADDR_W, 5, word-address width; array depth is 2**ADDR_W words.
- DATA_W, 32, data width; must be a multiple of 8; byte lanes = DATA_W/8.
- WAIT_STATES, 1, extra cycles between request capture and the memory operation; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-low reset.
- read_i  input  1  read request.
- write_i  input  1  write request.
- adr_i  input  ADDR_W  word address.
- cpu_dat_i  input  DATA_W  write data.
- sel_i  input  DATA_W/8  byte-lane write enables; bit k enables bits 8k+7:8k.
- cpu_dat_o  output  DATA_W  read data, registered.
- busy_o  output  1  request in progress; new requests are ignored while high.
- ack_o  output  1  one-cycle completion pulse, registered.

Behaviour:
- Single clock clk; reset rst is synchronous, active-low, and sampled only on the rising edge of clk.
- Reset values (on a rising edge with rst=0): state=IDLE, busy_o=0, ack_o=0, cpu_dat_o=0, wait counter=0, all array words=0, latched request cleared.
- Reset has priority over every other action. A reset edge aborts any in-flight request, and no array write occurs on that edge, even if the FSM was in DONE.
- FSM states:
  - IDLE: busy_o=0. On an edge with read_i|write_i=1, latch adr_i, cpu_dat_i, sel_i and op, then set busy_o<=1. If WAIT_STATES>0, go to WAIT with counter<=WAIT_STATES; otherwise go to DONE.
  - WAIT: counter decrements each edge; on the edge where counter==1, go to DONE. busy_o stays 1.
  - DONE: perform the operation on this edge, then busy_o<=0, ack_o<=1, state<=IDLE.
    - Write: update only the lanes with latched sel=1.
    - Read: cpu_dat_o<=array[latched adr].
- ack_o is 0 on every edge except the DONE edge, giving exactly one high cycle per request.
- Latency: request seen at edge N gives busy_o=1 for WAIT_STATES+1 cycles. ack_o=1 and read data are valid in the cycle after edge N+WAIT_STATES+1.
- Back-to-back: the FSM is in IDLE during the ack cycle, so a request held high in that cycle is accepted at the next edge with no dead cycle.
- Inputs are ignored outside IDLE; changes to adr_i, cpu_dat_i or sel_i during busy do not affect the in-flight operation.
- read_i=1 and write_i=1 together: treated as a write; no read data is returned.
- A write with sel_i=0 changes no array word but still completes with a full busy/ack sequence.
- Reads ignore sel_i and return the full word.
- cpu_dat_o holds its last read value through writes and idle cycles; only a completed read updates it.
- Address space is exactly 2**ADDR_W words; no out-of-range case exists.
- Array read is synchronous, taken from the latched address, so no combinational path from adr_i to cpu_dat_o.

Decomposition:
- Package sram_bus_pkg: state enum (IDLE, WAIT, DONE) and op enum (OP_READ, OP_WRITE).
- Sub-module sram_word_array (clk, rst, we, adr, sel, wdata, re, rdata): byte-lane write, registered read, zero on synchronous reset.
- The FSM, wait counter and handshake logic stay in the top module.

Test Plan:
- Reset, then idle for 5 cycles -> busy_o=0, ack_o=0, cpu_dat_o=0; a read of adr 3 returns 0x00000000.
- WAIT_STATES=1: write adr=5, data=0xDEADBEEF, sel=0xF, pulsed for one cycle at edge N -> busy_o=1 for 2 cycles, ack_o=1 in exactly one cycle. A following read of adr 5 returns 0xDEADBEEF with ack_o at N'+2.
- Partial write: sel=0x3, data=0x11223344 to adr 5 (holding 0xDEADBEEF) -> a read returns 0xDEAD3344.
- read_i held high continuously, adr_i switched 5->7 during busy -> first ack returns the adr-5 word. The next request is accepted on the edge after ack, with no gap cycle, and returns the adr-7 word.
- read_i=write_i=1, adr=2, data=0xA5A5A5A5, sel=0xF -> cpu_dat_o unchanged; a later read of adr 2 returns 0xA5A5A5A5.
- Write issued, rst=0 asserted while in DONE state -> no ack; after reset busy_o=0 and a read of that address returns 0.
